// File: rtl/skew_addr_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : skew_addr_pkg                                                    |
// | Brief   : Shared types and helpers for the skewed address sequencer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package skew_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int c_idle_addr = 127;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Final wavefront step: the widest array's last lane finishes its L-th element.
  function automatic int calc_last(input int len, input int nlanes);
    return len + nlanes - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_addr_gen_if.sv
// +----------------------------------------------------------------------------+
// | Module  : skew_addr_gen_if                                                 |
// | Brief   : Control/command and bank-address bundle of the skew sequencer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface skew_addr_gen_if #(
  parameter int NUM_W  = 32,
  parameter int NUM_D  = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 7
);

  logic                    start;
  logic [LEN_W-1:0]        queue_len;
  logic [ADDR_W-1:0]       base_w;
  logic [ADDR_W-1:0]       base_d;
  logic                    stall;
  logic [NUM_W*ADDR_W-1:0] raddr_w;
  logic [NUM_D*ADDR_W-1:0] raddr_d;
  logic [NUM_W-1:0]        ren_w;
  logic [NUM_D-1:0]        ren_d;
  logic [LEN_W+5:0]        serial_num;
  logic                    busy;
  logic                    done;

  modport master (
    output start, queue_len, base_w, base_d, stall,
    input  raddr_w, raddr_d, ren_w, ren_d, serial_num, busy, done
  );

  modport slave (
    input  start, queue_len, base_w, base_d, stall,
    output raddr_w, raddr_d, ren_w, ren_d, serial_num, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/skew_addr_lane.sv
// +----------------------------------------------------------------------------+
// | Module  : skew_addr_lane                                                   |
// | Brief   : One bank lane: window test against step k, offset add, register. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module skew_addr_lane #(
  parameter int                LANE_IDX  = 0,
  parameter int                ADDR_W    = 10,
  parameter int                LEN_W     = 7,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(127)
) (
  input  wire logic              clk,
  input  wire logic              srstn,
  input  wire logic              issue,
  input  wire logic              clear,
  input  wire logic [LEN_W+5:0]  k,
  input  wire logic [LEN_W-1:0]  len,
  input  wire logic [ADDR_W-1:0] base,
  output logic      [ADDR_W-1:0] addr,
  output logic                   ren
);

  localparam int c_cnt_w = LEN_W + 6;

  logic [c_cnt_w-1:0] w_off;
  logic               w_act;
  logic [ADDR_W-1:0]  w_addr;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_ren;

  assign w_off  = k - c_cnt_w'(LANE_IDX);
  assign w_act  = (k >= c_cnt_w'(LANE_IDX)) && (w_off < c_cnt_w'(len));
  assign w_addr = base + ADDR_W'(w_off);

  // A stalled cycle keeps the last address but withdraws the read enable.
  always_ff @(posedge clk) begin
    if (!srstn || clear) begin
      r_addr <= IDLE_ADDR;
      r_ren  <= 1'b0;
    end else if (issue) begin
      r_addr <= w_act ? w_addr : IDLE_ADDR;
      r_ren  <= w_act;
    end else begin
      r_ren  <= 1'b0;
    end
  end

  assign addr = r_addr;
  assign ren  = r_ren;

endmodule

`default_nettype wire

// File: rtl/skew_addr_gen.sv
// +----------------------------------------------------------------------------+
// | Module  : skew_addr_gen                                                    |
// | Brief   : Diagonal-wavefront read-address sequencer for systolic SRAMs.    |
// |           Optional stall support under macro SKEW_ADDR_STALL_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module skew_addr_gen
  import skew_addr_pkg::*;
#(
  parameter int                NUM_W     = 32,
  parameter int                NUM_D     = 32,
  parameter int                ADDR_W    = 10,
  parameter int                LEN_W     = 7,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(c_idle_addr)
) (
  input wire logic        clk,
  input wire logic        srstn,
  skew_addr_gen_if.slave  bus
);

  localparam int c_max_n = max2(NUM_W, NUM_D);
  localparam int c_cnt_w = LEN_W + 6;

  state_t                  r_state;
  logic [c_cnt_w-1:0]      r_k;
  logic [LEN_W-1:0]        r_len;
  logic [ADDR_W-1:0]       r_base_w;
  logic [ADDR_W-1:0]       r_base_d;
  logic [c_cnt_w-1:0]      r_serial;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_stall;
  logic                    w_issue;
  logic                    w_clear;
  logic [c_cnt_w-1:0]      w_last;
  logic [NUM_W*ADDR_W-1:0] w_raddr_w;
  logic [NUM_D*ADDR_W-1:0] w_raddr_d;
  logic [NUM_W-1:0]        w_ren_w;
  logic [NUM_D-1:0]        w_ren_d;

`ifdef SKEW_ADDR_STALL_EN
  assign w_stall = bus.stall;
`else
  assign w_stall = bus.stall & 1'b0;
`endif

  assign w_last  = c_cnt_w'(calc_last(int'(r_len), c_max_n));
  assign w_issue = (r_state == ST_RUN) && !w_stall;
  assign w_clear = (r_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_state  <= ST_IDLE;
      r_k      <= '0;
      r_len    <= '0;
      r_base_w <= '0;
      r_base_d <= '0;
      r_serial <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done   <= 1'b0;
          r_serial <= '0;
          if (bus.start) begin
            r_len    <= bus.queue_len;
            r_base_w <= bus.base_w;
            r_base_d <= bus.base_d;
            r_k      <= '0;
            r_busy   <= 1'b1;
            // An empty pass still reports completion through FIN.
            if (bus.queue_len == '0) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!w_stall) begin
            r_serial <= r_k;
            r_k      <= r_k + c_cnt_w'(1);
            if (r_k == w_last) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FIN: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_serial <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar j = 0; j < NUM_W; j++) begin : g_lane_w
    skew_addr_lane #(
      .LANE_IDX (j),
      .ADDR_W   (ADDR_W),
      .LEN_W    (LEN_W),
      .IDLE_ADDR(IDLE_ADDR)
    ) u_lane (
      .clk  (clk),
      .srstn(srstn),
      .issue(w_issue),
      .clear(w_clear),
      .k    (r_k),
      .len  (r_len),
      .base (r_base_w),
      .addr (w_raddr_w[j*ADDR_W +: ADDR_W]),
      .ren  (w_ren_w[j])
    );
  end

  for (genvar j = 0; j < NUM_D; j++) begin : g_lane_d
    skew_addr_lane #(
      .LANE_IDX (j),
      .ADDR_W   (ADDR_W),
      .LEN_W    (LEN_W),
      .IDLE_ADDR(IDLE_ADDR)
    ) u_lane (
      .clk  (clk),
      .srstn(srstn),
      .issue(w_issue),
      .clear(w_clear),
      .k    (r_k),
      .len  (r_len),
      .base (r_base_d),
      .addr (w_raddr_d[j*ADDR_W +: ADDR_W]),
      .ren  (w_ren_d[j])
    );
  end

  assign bus.raddr_w    = w_raddr_w;
  assign bus.raddr_d    = w_raddr_d;
  assign bus.ren_w      = w_ren_w;
  assign bus.ren_d      = w_ren_d;
  assign bus.serial_num = r_serial;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_skew_addr_gen.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_skew_addr_gen                                                 |
// | Brief   : Scoreboard bench for skew_addr_gen (4x4 and 2x5 configurations). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_skew_addr_gen;

  localparam int NW = 4;
  localparam int ND = 4;
  localparam int AW = 10;
  localparam int LW = 7;
  localparam int CW = LW + 6;

`ifdef SKEW_ADDR_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  typedef struct {
    logic [NW*AW-1:0] aw;
    logic [NW-1:0]    rw;
    logic [ND*AW-1:0] ad;
    logic [ND-1:0]    rd;
    logic [CW-1:0]    sn;
    logic             busy;
    logic             done;
  } exp_t;

  logic clk;
  logic srstn;
  int   n_checks;
  int   n_fail;
  exp_t q[$];

  skew_addr_gen_if #(.NUM_W(NW), .NUM_D(ND), .ADDR_W(AW), .LEN_W(LW)) bus1 ();
  skew_addr_gen_if #(.NUM_W(2),  .NUM_D(5),  .ADDR_W(AW), .LEN_W(LW)) bus2 ();

  skew_addr_gen #(.NUM_W(NW), .NUM_D(ND), .ADDR_W(AW), .LEN_W(LW), .IDLE_ADDR(10'd127)) u_dut (
    .clk  (clk),
    .srstn(srstn),
    .bus  (bus1)
  );

  skew_addr_gen #(.NUM_W(2), .NUM_D(5), .ADDR_W(AW), .LEN_W(LW), .IDLE_ADDR(10'd127)) u_dut2 (
    .clk  (clk),
    .srstn(srstn),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t lanes_exp(input int k, input int len, input int bw, input int bd);
    exp_t e;
    for (int j = 0; j < NW; j++) begin
      if (j <= k && k <= j + len - 1) begin
        e.aw[j*AW +: AW] = AW'(bw + k - j);
        e.rw[j] = 1'b1;
      end else begin
        e.aw[j*AW +: AW] = 10'd127;
        e.rw[j] = 1'b0;
      end
    end
    for (int j = 0; j < ND; j++) begin
      if (j <= k && k <= j + len - 1) begin
        e.ad[j*AW +: AW] = AW'(bd + k - j);
        e.rd[j] = 1'b1;
      end else begin
        e.ad[j*AW +: AW] = 10'd127;
        e.rd[j] = 1'b0;
      end
    end
    e.sn   = '0;
    e.busy = 1'b0;
    e.done = 1'b0;
    return e;
  endfunction

  task automatic check_entry(input string tag, input exp_t e);
    check_val({tag, ".raddr_w"}, 64'(bus1.raddr_w), 64'(e.aw));
    check_val({tag, ".ren_w"},   64'(bus1.ren_w),   64'(e.rw));
    check_val({tag, ".raddr_d"}, 64'(bus1.raddr_d), 64'(e.ad));
    check_val({tag, ".ren_d"},   64'(bus1.ren_d),   64'(e.rd));
    check_val({tag, ".serial"},  64'(bus1.serial_num), 64'(e.sn));
    check_val({tag, ".busy"},    64'(bus1.busy),    64'(e.busy));
    check_val({tag, ".done"},    64'(bus1.done),    64'(e.done));
  endtask

  // Builds the expected per-cycle output stream, then drives the pass and drains the queue.
  task automatic run_pass(input string tag, input int len, input int bw, input int bd,
                          input int stall_edge, input int stall_cnt, input bit poke_start);
    exp_t cur;
    int   last;
    int   k;
    int   c;
    bit   st;
    bit   fin;
    last = len + 4 - 2;
    q.delete();
    cur = lanes_exp(-1, 0, bw, bd);
    cur.busy = 1'b1;
    cur.done = (len == 0);
    q.push_back(cur);
    if (len > 0) begin
      k   = 0;
      fin = 1'b0;
      for (int e = 1; e < 200 && !fin; e++) begin
        st = STALL_ON && (e >= stall_edge) && (e < stall_edge + stall_cnt);
        if (st) begin
          cur.rw   = '0;
          cur.rd   = '0;
          cur.done = 1'b0;
        end else begin
          cur = lanes_exp(k, len, bw, bd);
          cur.sn   = CW'(k);
          cur.busy = 1'b1;
          cur.done = (k == last);
          if (k == last) fin = 1'b1;
          k++;
        end
        q.push_back(cur);
      end
    end
    q.push_back(lanes_exp(-1, 0, bw, bd));

    @(negedge clk);
    bus1.start     = 1'b1;
    bus1.queue_len = LW'(len);
    bus1.base_w    = AW'(bw);
    bus1.base_d    = AW'(bd);
    @(posedge clk);
    c = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      check_entry($sformatf("%s.c%0d", tag, c), q.pop_front());
      bus1.start = poke_start && (c == 1);
      bus1.stall = (c + 1 >= stall_edge) && (c + 1 < stall_edge + stall_cnt);
      c++;
    end
    bus1.start = 1'b0;
    bus1.stall = 1'b0;
  endtask

  initial begin
    exp_t idle;
    int   done_c;
    n_checks = 0;
    n_fail   = 0;
    srstn = 1'b0;
    bus1.start = 1'b0; bus1.queue_len = '0; bus1.base_w = '0; bus1.base_d = '0; bus1.stall = 1'b0;
    bus2.start = 1'b0; bus2.queue_len = '0; bus2.base_w = '0; bus2.base_d = '0; bus2.stall = 1'b0;
    idle = lanes_exp(-1, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    srstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_entry($sformatf("idle%0d", i), idle);
    end

    run_pass("p1", 3, 'h100, 'h200, 0, 0, 1'b0);
    run_pass("zero", 0, 'h100, 'h200, 0, 0, 1'b0);
    run_pass("poke", 3, 'h010, 'h020, 0, 0, 1'b1);
    run_pass("wrap", 2, 'h3FF, 'h3FE, 0, 0, 1'b0);

    // Abort at the cycle showing k=2.
    @(negedge clk);
    bus1.start = 1'b1; bus1.queue_len = 7'd3; bus1.base_w = 10'h100; bus1.base_d = 10'h200;
    @(posedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst.pre_serial", 64'(bus1.serial_num), 64'd2);
    srstn = 1'b0;
    @(negedge clk);
    check_entry("rst.abort", idle);
    srstn = 1'b1;
    @(negedge clk);
    check_entry("rst.after", idle);
    run_pass("rst.new", 3, 'h100, 'h200, 0, 0, 1'b0);

    run_pass("stall", 3, 'h100, 'h200, 4, 2, 1'b0);

    // 2 weight / 5 data banks: LAST = 2 + 5 - 2 = 5.
    @(negedge clk);
    bus2.start = 1'b1; bus2.queue_len = 7'd2; bus2.base_w = 10'h040; bus2.base_d = 10'h050;
    @(posedge clk);
    done_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      if (bus2.done && done_c < 0) begin
        done_c = c;
        check_val("d2.serial", 64'(bus2.serial_num), 64'd5);
        check_val("d2.ren_d",  64'(bus2.ren_d),      64'h10);
        check_val("d2.addr_d4", 64'(bus2.raddr_d[4*AW +: AW]), 64'h051);
        check_val("d2.ren_w",  64'(bus2.ren_w),      64'h0);
      end
    end
    check_val("d2.done_cycle", 64'(done_c), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
